// File: rtl/and_hpc1_d3_feeder.sv
// rtl/and_hpc1_d3_feeder.sv - 4-share masking front end and randomness source for a d=3 HPC1 AND gadget
module and_hpc1_d3_feeder #(
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic        clock_0,
  input  logic        reset_0,
  input  logic        seed_valid,
  input  logic [31:0] seed_data,
  input  logic        in_valid,
  input  logic        in_a,
  input  logic        in_b,
  output logic        in_ready,
  output logic        io_i0_s0,
  output logic        io_i0_s1,
  output logic        io_i0_s2,
  output logic        io_i0_s3,
  output logic        io_i1_s0,
  output logic        io_i1_s1,
  output logic        io_i1_s2,
  output logic        io_i1_s3,
  output logic        p_rand_0,
  output logic        p_rand_1,
  output logic        p_rand_2,
  output logic        p_rand_3,
  output logic        p_rand_4,
  output logic        p_rand_5,
  output logic        p_rand_6,
  output logic        p_rand_7,
  output logic        p_rand_8,
  output logic        p_rand_9,
  output logic        p_rand_10,
  output logic        p_rand_11,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_adv;
  logic [17:0] rnd;
  logic [7:0]  warm_cnt;
  logic [3:0]  sh_a;
  logic [3:0]  sh_b;
  logic [11:0] prand;
  logic        transfer;

  // Eighteen serial LFSR steps unrolled; rnd[i] is the i-th feedback bit produced.
  always_comb begin
    lfsr_adv = lfsr;
    rnd      = '0;
    for (int i = 0; i < 18; i++) begin
      rnd[i]   = lfsr_adv[31] ^ lfsr_adv[21] ^ lfsr_adv[1] ^ lfsr_adv[0];
      lfsr_adv = {lfsr_adv[30:0], rnd[i]};
    end
  end

  assign in_ready = (state == RUN) && !seed_valid;
  assign transfer = in_valid && in_ready;

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      state     <= IDLE;
      lfsr      <= 32'h0000_0001;
      warm_cnt  <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      prand     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= transfer;
      // Operands only ever land here already XOR-masked; no plain copy is kept.
      if (transfer) begin
        sh_a <= {rnd[2], rnd[1], rnd[0], in_a ^ rnd[0] ^ rnd[1] ^ rnd[2]};
        sh_b <= {rnd[5], rnd[4], rnd[3], in_b ^ rnd[3] ^ rnd[4] ^ rnd[5]};
      end
      if (state == RUN) begin
        prand <= rnd[17:6];
      end
      if (seed_valid) begin
        lfsr     <= (seed_data == 32'h0) ? 32'h0000_0001 : seed_data;
        warm_cnt <= '0;
        state    <= WARMUP;
      end else begin
        case (state)
          IDLE: begin
            lfsr <= lfsr;
          end
          WARMUP: begin
            lfsr <= lfsr_adv;
            if (warm_cnt == WARM_LAST) begin
              state <= RUN;
            end else begin
              warm_cnt <= warm_cnt + 8'd1;
            end
          end
          RUN: begin
            lfsr <= lfsr_adv;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign io_i0_s0  = sh_a[0];
  assign io_i0_s1  = sh_a[1];
  assign io_i0_s2  = sh_a[2];
  assign io_i0_s3  = sh_a[3];
  assign io_i1_s0  = sh_b[0];
  assign io_i1_s1  = sh_b[1];
  assign io_i1_s2  = sh_b[2];
  assign io_i1_s3  = sh_b[3];
  assign p_rand_0  = prand[0];
  assign p_rand_1  = prand[1];
  assign p_rand_2  = prand[2];
  assign p_rand_3  = prand[3];
  assign p_rand_4  = prand[4];
  assign p_rand_5  = prand[5];
  assign p_rand_6  = prand[6];
  assign p_rand_7  = prand[7];
  assign p_rand_8  = prand[8];
  assign p_rand_9  = prand[9];
  assign p_rand_10 = prand[10];
  assign p_rand_11 = prand[11];

endmodule

// File: tb/tb_and_hpc1_d3_feeder.sv
// tb/tb_and_hpc1_d3_feeder.sv - randomized model-checked bench for and_hpc1_d3_feeder
module tb_and_hpc1_d3_feeder;

  localparam int W = 16;

  logic        clock_0;
  logic        reset_0;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        in_valid, in_a, in_b;
  logic        in_ready, out_valid;
  logic        io_i0_s0, io_i0_s1, io_i0_s2, io_i0_s3;
  logic        io_i1_s0, io_i1_s1, io_i1_s2, io_i1_s3;
  logic        p_rand_0, p_rand_1, p_rand_2, p_rand_3, p_rand_4, p_rand_5;
  logic        p_rand_6, p_rand_7, p_rand_8, p_rand_9, p_rand_10, p_rand_11;

  and_hpc1_d3_feeder #(.WARMUP_CYCLES(W)) dut (
    .clock_0(clock_0), .reset_0(reset_0),
    .seed_valid(seed_valid), .seed_data(seed_data),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .io_i0_s0(io_i0_s0), .io_i0_s1(io_i0_s1), .io_i0_s2(io_i0_s2), .io_i0_s3(io_i0_s3),
    .io_i1_s0(io_i1_s0), .io_i1_s1(io_i1_s1), .io_i1_s2(io_i1_s2), .io_i1_s3(io_i1_s3),
    .p_rand_0(p_rand_0), .p_rand_1(p_rand_1), .p_rand_2(p_rand_2), .p_rand_3(p_rand_3),
    .p_rand_4(p_rand_4), .p_rand_5(p_rand_5), .p_rand_6(p_rand_6), .p_rand_7(p_rand_7),
    .p_rand_8(p_rand_8), .p_rand_9(p_rand_9), .p_rand_10(p_rand_10), .p_rand_11(p_rand_11),
    .out_valid(out_valid)
  );

  initial begin
    clock_0 = 1'b0;
    forever #5 clock_0 = ~clock_0;
  end

  wire [7:0]  d_sh = {io_i1_s3, io_i1_s2, io_i1_s1, io_i1_s0, io_i0_s3, io_i0_s2, io_i0_s1, io_i0_s0};
  wire [11:0] d_pr = {p_rand_11, p_rand_10, p_rand_9, p_rand_8, p_rand_7, p_rand_6,
                      p_rand_5, p_rand_4, p_rand_3, p_rand_2, p_rand_1, p_rand_0};

  int checks = 0;
  int errors = 0;

  // Behavioural reference: "seeded" plus number of warm-up advances already done.
  logic        m_seeded;
  int          m_warm;
  logic [31:0] m_L;
  logic [7:0]  m_sh;
  logic [11:0] m_pr;
  logic        m_ov;
  logic        m_a, m_b;

  logic        g_v;
  logic [3:0]  g_a, g_b;
  logic        g_exp;
  int          gadget_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv_n(input logic [31:0] l, input int n, output logic [17:0] r);
    logic fb;
    r = '0;
    for (int k = 0; k < n; k++) begin
      fb = l[31] ^ l[21] ^ l[1] ^ l[0];
      if (k < 18) r[k] = fb;
      l = {l[30:0], fb};
    end
    return l;
  endfunction

  task automatic model_reset();
    m_seeded = 1'b0; m_warm = 0; m_L = 32'h1;
    m_sh = '0; m_pr = '0; m_ov = 1'b0; m_a = 1'b0; m_b = 1'b0;
    g_v = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic [31:0] sd, input logic iv, ia, ib);
    logic        run, xfer;
    logic [17:0] rr;
    logic [31:0] ladv;
    run  = m_seeded && (m_warm == W);
    ladv = adv_n(m_L, 18, rr);
    xfer = run && !sv && iv;
    m_ov = xfer;
    if (xfer) begin
      m_sh[3:0] = {rr[2], rr[1], rr[0], ia ^ rr[0] ^ rr[1] ^ rr[2]};
      m_sh[7:4] = {rr[5], rr[4], rr[3], ib ^ rr[3] ^ rr[4] ^ rr[5]};
      m_a = ia; m_b = ib;
    end
    if (run) m_pr = rr[17:6];
    if (sv) begin
      m_L = (sd == 32'h0) ? 32'h1 : sd;
      m_seeded = 1'b1; m_warm = 0;
    end else if (m_seeded) begin
      m_L = ladv;
      if (m_warm < W) m_warm++;
    end
  endtask

  // Downstream d=3 HPC1 AND: refresh b with p_rand[5:0], then DOM product with the next cycle's p_rand[11:6].
  task automatic gadget_step();
    logic [3:0] c;
    logic       rm [4][4];
    int         p;
    if (g_v) begin
      p = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++) begin
          rm[i][j] = d_pr[6 + p]; rm[j][i] = d_pr[6 + p]; p++;
        end
      for (int i = 0; i < 4; i++) begin
        c[i] = g_a[i] & g_b[i];
        for (int j = 0; j < 4; j++)
          if (j != i) c[i] = c[i] ^ (g_a[i] & g_b[j]) ^ rm[i][j];
      end
      chk("gadget_and", {31'b0, ^c}, {31'b0, g_exp});
      gadget_checks++;
    end
    g_v = out_valid;
    if (out_valid) begin
      g_a = d_sh[3:0];
      g_b = d_sh[7:4];
      p = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++) begin
          g_b[i] = g_b[i] ^ d_pr[p]; g_b[j] = g_b[j] ^ d_pr[p]; p++;
        end
      g_exp = m_a & m_b;
    end
  endtask

  task automatic drive_cycle(input logic sv, input logic [31:0] sd, input logic iv, ia, ib,
                             output logic rdy);
    @(negedge clock_0);
    seed_valid = sv; seed_data = sd; in_valid = iv; in_a = ia; in_b = ib;
    #1;
    rdy = in_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_seeded && (m_warm == W) && !sv});
    @(posedge clock_0);
    #1;
    model_edge(sv, sd, iv, ia, ib);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    chk("shares", {24'b0, d_sh}, {24'b0, m_sh});
    chk("p_rand", {20'b0, d_pr}, {20'b0, m_pr});
    chk("lfsr", dut.lfsr, m_L);
    if (m_ov) begin
      chk("recomb_a", {31'b0, ^d_sh[3:0]}, {31'b0, m_a});
      chk("recomb_b", {31'b0, ^d_sh[7:4]}, {31'b0, m_b});
    end
    gadget_step();
  endtask

  task automatic rnd_cycle(input logic sv, input logic [31:0] sd, input int iv_pct, output logic rdy);
    drive_cycle(sv, sd, ($urandom_range(0, 99) < iv_pct), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), rdy);
  endtask

  initial begin
    logic        rdy;
    logic [17:0] rr;
    int          cnt;
    seed_valid = 1'b0; seed_data = '0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
    reset_0 = 1'b0;
    model_reset();

    // Hand-derived: four steps from 1 give 1,3,6,13,27 with feedback bits 1,0,1,1.
    chk("pin_step4", adv_n(32'h1, 4, rr), 32'h0000_001B);
    chk("pin_bits4", {28'b0, rr[3:0]}, 32'hD);

    repeat (3) @(negedge clock_0);
    reset_0 = 1'b1;
    #1;
    chk("rst_outputs", {19'b0, in_ready, out_valid, d_sh, d_pr[3:0]}, 32'h0);
    chk("rst_lfsr", dut.lfsr, 32'h1);

    // Unseeded: nothing may start no matter what arrives on in_valid.
    repeat (50) rnd_cycle(1'b0, 32'h0, 80, rdy);

    drive_cycle(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, rdy);
    chk("seed0_lfsr", dut.lfsr, 32'h1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      rnd_cycle(1'b0, 32'h0, 50, rdy);
      if (rdy) break;
      cnt++;
    end
    chk("warmup_len", cnt, 16);

    repeat (1000) rnd_cycle(1'b0, 32'h0, 75, rdy);

    // Reseed collides with an offered operand pair: reseed wins.
    drive_cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0, rdy);
    chk("reseed_rdy", {31'b0, rdy}, 32'h0);
    chk("reseed_no_ov", {31'b0, out_valid}, 32'h0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      rnd_cycle(1'b0, 32'h0, 100, rdy);
      if (!rdy) cnt++;
    end
    chk("reseed_low16", cnt, 16);
    rnd_cycle(1'b0, 32'h0, 100, rdy);
    chk("reseed_ready", {31'b0, rdy}, 32'h1);

    for (int k = 0; k < 8000 && gadget_checks < 4200; k++)
      rnd_cycle(($urandom_range(0, 499) == 0), $urandom, 95, rdy);
    chk("gadget_pairs", {31'b0, gadget_checks >= 4096}, 32'h1);

    cnt = 0;
    for (int k = 0; k < 40 && !m_ov; k++) begin
      rnd_cycle(1'b0, 32'h0, 100, rdy);
      cnt++;
    end
    chk("pre_rst_ov", {31'b0, out_valid}, 32'h1);
    #2;
    reset_0 = 1'b0;
    #1;
    chk("async_rst", {19'b0, in_ready, out_valid, d_sh, d_pr[3:0]}, 32'h0);
    chk("async_rst_pr", {20'b0, d_pr}, 32'h0);
    chk("async_rst_lfsr", dut.lfsr, 32'h1);
    model_reset();
    @(negedge clock_0);
    reset_0 = 1'b1;
    repeat (10) rnd_cycle(1'b0, 32'h0, 100, rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
